cordic_job_arbiter: RTL and testbench

//  Shares one pipelined vector_cordic between two requesters. Accepts (x,y) jobs

---
 rtl/cordic_job_arbiter.sv | 158 +++++++++++++++
 tb/tb_cordic_job_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cordic_job_arbiter.sv
// cordic_job_arbiter: round-robin sharing of one pipelined vector CORDIC
// between two requesters, with a tag FIFO routing results to their owner.
//
// Ports:
//   Clk, Reset                      clock, synchronous active-high reset
//   reqN_valid/ready/x/y (N=0,1)    job request handshake and operands
//   cor_start/x/y/z                 issue to CORDIC (z is always zero)
//   cor_done/rootxy/atanba          CORDIC results, in issue order
//   rspN_valid, rsp_rootxy/atanba   one-cycle result pulse to owner
//   busy                            jobs in flight or Start pending
//   err_orphan                      sticky: result arrived with no job pending
module cordic_job_arbiter #(
    parameter int DEPTH = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_x,
    input  logic [15:0] req0_y,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_x,
    input  logic [15:0] req1_y,
    output logic        cor_start,
    output logic [15:0] cor_x,
    output logic [15:0] cor_y,
    output logic [15:0] cor_z,
    input  logic        cor_done,
    input  logic [15:0] cor_rootxy,
    input  logic [15:0] cor_atanba,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [15:0] rsp_rootxy,
    output logic [15:0] rsp_atanba,
    output logic        busy,
    output logic        err_orphan
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] tags_q, tags_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             prio_q, prio_d;
    logic             cor_start_q, cor_start_d;
    logic [15:0]      cor_x_q, cor_x_d;
    logic [15:0]      cor_y_q, cor_y_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic [15:0]      rsp_rootxy_q, rsp_rootxy_d;
    logic [15:0]      rsp_atanba_q, rsp_atanba_d;
    logic             err_orphan_q, err_orphan_d;

    logic space;
    logic grant0;
    logic grant1;
    logic push;
    logic pop;
    logic head_tag;

    // Space uses the pre-pop count, so a same-cycle pop never frees a slot.
    assign space  = (count_q < CW'(DEPTH));
    assign grant0 = req0_valid & (~req1_valid | ~prio_q);
    assign grant1 = req1_valid & (~req0_valid | prio_q);

    assign req0_ready = grant0 & space;
    assign req1_ready = grant1 & space;

    assign push     = req0_ready | req1_ready;
    assign pop      = cor_done & (count_q != '0);
    assign head_tag = tags_q[rd_ptr_q];

    always_comb begin
        tags_d       = tags_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        prio_d       = prio_q;
        cor_start_d  = push;
        cor_x_d      = cor_x_q;
        cor_y_d      = cor_y_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp_rootxy_d = rsp_rootxy_q;
        rsp_atanba_d = rsp_atanba_q;
        err_orphan_d = err_orphan_q | (cor_done & (count_q == '0));

        if (push) begin
            // Tag 1 means requester 1 owns the job.
            tags_d[wr_ptr_q] = req1_ready;
            wr_ptr_d         = wr_ptr_q + AW'(1);
            prio_d           = req0_ready;
            cor_x_d          = req1_ready ? req1_x : req0_x;
            cor_y_d          = req1_ready ? req1_y : req0_y;
        end

        if (pop) begin
            rd_ptr_d     = rd_ptr_q + AW'(1);
            rsp0_valid_d = ~head_tag;
            rsp1_valid_d = head_tag;
            rsp_rootxy_d = cor_rootxy;
            rsp_atanba_d = cor_atanba;
        end

        if (push & ~pop) begin
            count_d = count_q + CW'(1);
        end else if (pop & ~push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            tags_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            prio_q       <= 1'b0;
            cor_start_q  <= 1'b0;
            cor_x_q      <= '0;
            cor_y_q      <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_rootxy_q <= '0;
            rsp_atanba_q <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            tags_q       <= tags_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            prio_q       <= prio_d;
            cor_start_q  <= cor_start_d;
            cor_x_q      <= cor_x_d;
            cor_y_q      <= cor_y_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp_rootxy_q <= rsp_rootxy_d;
            rsp_atanba_q <= rsp_atanba_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign cor_start  = cor_start_q;
    assign cor_x      = cor_x_q;
    assign cor_y      = cor_y_q;
    assign cor_z      = 16'h0000;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp_rootxy = rsp_rootxy_q;
    assign rsp_atanba = rsp_atanba_q;
    assign busy       = (count_q != '0) | cor_start_q;
    assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_cordic_job_arbiter.sv
// tb_cordic_job_arbiter: directed bench for cordic_job_arbiter with a
// tag scoreboard and a cycle-level expectation of every output.
module tb_cordic_job_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [15:0] req0_x = '0;
    logic [15:0] req0_y = '0;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [15:0] req1_x = '0;
    logic [15:0] req1_y = '0;
    logic        cor_start;
    logic [15:0] cor_x;
    logic [15:0] cor_y;
    logic [15:0] cor_z;
    logic        cor_done = 1'b0;
    logic [15:0] cor_rootxy = '0;
    logic [15:0] cor_atanba = '0;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [15:0] rsp_rootxy;
    logic [15:0] rsp_atanba;
    logic        busy;
    logic        err_orphan;

    cordic_job_arbiter #(.DEPTH(8)) dut (
        .Clk(Clk), .Reset(Reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_x(req1_x), .req1_y(req1_y),
        .cor_start(cor_start), .cor_x(cor_x), .cor_y(cor_y), .cor_z(cor_z),
        .cor_done(cor_done), .cor_rootxy(cor_rootxy), .cor_atanba(cor_atanba),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_rootxy(rsp_rootxy), .rsp_atanba(rsp_atanba),
        .busy(busy), .err_orphan(err_orphan)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // Expected state: owner tags of jobs in flight plus last register values.
    bit          tagq[$];
    bit          m_prio;
    bit          m_err;
    logic [15:0] m_x, m_y, m_rr, m_ra;
    int          acc0, acc1, rsp0_cnt, rsp1_cnt;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        tagq.delete();
        m_prio = 1'b0;
        m_err  = 1'b0;
        m_x = '0; m_y = '0; m_rr = '0; m_ra = '0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; cor_done = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b0;
        model_reset();
        chk("rst_start", 32'(cor_start), 0);
        chk("rst_rsp0", 32'(rsp0_valid), 0);
        chk("rst_rsp1", 32'(rsp1_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_orphan", 32'(err_orphan), 0);
        chk("rst_corx", 32'(cor_x), 0);
        chk("rst_cory", 32'(cor_y), 0);
        chk("rst_rootxy", 32'(rsp_rootxy), 0);
        chk("rst_atanba", 32'(rsp_atanba), 0);
    endtask

    // One clock: drive inputs, check readies, advance, check registered outputs.
    task automatic step(input bit v0, input logic [15:0] x0, input logic [15:0] y0,
                        input bit v1, input logic [15:0] x1, input logic [15:0] y1,
                        input bit dn, input logic [15:0] rr, input logic [15:0] ra);
        bit space, e_r0, e_r1, acc, pop, ptag, e_s0, e_s1;
        req0_valid = v0; req0_x = x0; req0_y = y0;
        req1_valid = v1; req1_x = x1; req1_y = y1;
        cor_done = dn; cor_rootxy = rr; cor_atanba = ra;
        #1;
        space = (tagq.size() < 8);
        e_r0 = v0 && (!v1 || m_prio == 1'b0) && space;
        e_r1 = v1 && (!v0 || m_prio == 1'b1) && space;
        chk("req0_ready", 32'(req0_ready), 32'(e_r0));
        chk("req1_ready", 32'(req1_ready), 32'(e_r1));
        acc = e_r0 || e_r1;
        pop = dn && (tagq.size() != 0);
        ptag = 1'b0;
        if (pop) begin
            ptag = tagq.pop_front();
            m_rr = rr; m_ra = ra;
        end
        if (dn && !pop) m_err = 1'b1;
        if (acc) begin
            tagq.push_back(e_r1);
            m_x = e_r1 ? x1 : x0;
            m_y = e_r1 ? y1 : y0;
            m_prio = e_r0;
            if (e_r1) acc1++; else acc0++;
        end
        e_s0 = pop && !ptag;
        e_s1 = pop && ptag;
        if (e_s0) rsp0_cnt++;
        if (e_s1) rsp1_cnt++;
        @(posedge Clk); #1;
        chk("cor_start", 32'(cor_start), 32'(acc));
        chk("cor_x", 32'(cor_x), 32'(m_x));
        chk("cor_y", 32'(cor_y), 32'(m_y));
        chk("cor_z", 32'(cor_z), 0);
        chk("rsp0_valid", 32'(rsp0_valid), 32'(e_s0));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(e_s1));
        chk("rsp_rootxy", 32'(rsp_rootxy), 32'(m_rr));
        chk("rsp_atanba", 32'(rsp_atanba), 32'(m_ra));
        chk("busy", 32'(busy), 32'((tagq.size() != 0) || acc));
        chk("err_orphan", 32'(err_orphan), 32'(m_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic done1(input logic [15:0] rr, input logic [15:0] ra);
        step(0, 0, 0, 0, 0, 0, 1, rr, ra);
    endtask

    initial begin
        model_reset();
        acc0 = 0; acc1 = 0; rsp0_cnt = 0; rsp1_cnt = 0;

        // Reset and first job from requester 0.
        do_reset();
        step(1, 16'd3, 16'd4, 0, 0, 0, 0, 0, 0);
        chk("t1_acc0", 32'(acc0), 1);

        // Result 17 cycles after Start routes to requester 0.
        idle(16);
        done1(16'd5, 16'h1234);
        chk("t2_rsp0_cnt", 32'(rsp0_cnt), 1);
        chk("t2_rsp1_cnt", 32'(rsp1_cnt), 0);
        idle(2);

        // Fairness: both valid for 6 cycles alternate 0,1,0,1,0,1.
        do_reset();
        acc0 = 0; acc1 = 0; rsp0_cnt = 0; rsp1_cnt = 0;
        for (int i = 0; i < 6; i++)
            step(1, 16'(16'h100 + i), 16'(16'h200 + i),
                 1, 16'(16'h300 + i), 16'(16'h400 + i), 0, 0, 0);
        chk("t3_acc0", 32'(acc0), 3);
        chk("t3_acc1", 32'(acc1), 3);
        for (int i = 0; i < 6; i++) done1(16'(16'h50 + i), 16'(16'h60 + i));
        chk("t3_rsp0_cnt", 32'(rsp0_cnt), 3);
        chk("t3_rsp1_cnt", 32'(rsp1_cnt), 3);

        // Full: exactly 8 accepts, done does not free a slot the same cycle.
        do_reset();
        acc0 = 0; acc1 = 0;
        for (int i = 0; i < 11; i++)
            step(1, 16'(i), 16'(i + 1), 1, 16'(i + 2), 16'(i + 3), 0, 0, 0);
        chk("t4_full_accepts", 32'(acc0 + acc1), 8);
        step(1, 16'hAA, 16'hBB, 1, 16'hCC, 16'hDD, 1, 16'h11, 16'h22);
        chk("t4_no_early_accept", 32'(acc0 + acc1), 8);
        step(1, 16'hAA, 16'hBB, 1, 16'hCC, 16'hDD, 0, 0, 0);
        chk("t4_one_more_accept", 32'(acc0 + acc1), 9);
        for (int i = 0; i < 8; i++) done1(16'(16'h700 + i), 16'(16'h800 + i));
        idle(1);

        // Orphan result raises a sticky flag until Reset.
        do_reset();
        rsp0_cnt = 0; rsp1_cnt = 0;
        done1(16'h99, 16'h98);
        idle(3);
        chk("t5_no_rsp", 32'(rsp0_cnt + rsp1_cnt), 0);
        chk("t5_orphan_held", 32'(err_orphan), 1);
        do_reset();

        // Reset mid-flight, then a single requester 1 job is served.
        step(1, 16'd1, 16'd2, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 16'd3, 16'd4, 0, 0, 0);
        step(1, 16'd5, 16'd6, 0, 0, 0, 0, 0, 0);
        do_reset();
        rsp0_cnt = 0; rsp1_cnt = 0;
        step(0, 0, 0, 1, 16'h0abc, 16'h0def, 0, 0, 0);
        idle(5);
        done1(16'h0042, 16'h0777);
        chk("t6_rsp1_cnt", 32'(rsp1_cnt), 1);
        chk("t6_rsp0_cnt", 32'(rsp0_cnt), 0);
        idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
